// File: rtl/hex_scroll_ctrl.sv
// Scrolling marquee controller: buffers up to eight 3-bit character codes and
// presents a rotating five-slot window (characters plus one blank gap) to 7-segment decoders.
module hex_scroll_ctrl #(
   parameter int DIV = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_code,
   output logic        wr_ready,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic        clr,
   output logic [14:0] codes,
   output logic [4:0]  blank,
   output logic        busy,
   output logic [3:0]  count
);

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

   typedef enum logic {IDLE, SCROLL} state_t;

   state_t        state, state_nxt;
   logic [3:0]    count_nxt;
   logic [3:0]    offset, offset_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic          do_write;
   logic [4:0]    slot_idx;
   logic [2:0]    char_buf [8];

   assign wr_ready = (state == IDLE) && (count < 4'd8) && !start && !clr;
   assign busy     = (state == SCROLL);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         offset <= '0;
         tick   <= '0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         offset <= offset_nxt;
         tick   <= tick_nxt;
      end
   end

   // NOTE: the buffer is cleared on reset because the blank-gap view after
   // reset must read defined zeros, not power-up garbage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < 8; j++) char_buf[j] <= '0;
      end else if (do_write) begin
         char_buf[count[2:0]] <= wr_code;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      offset_nxt = offset;
      tick_nxt   = tick;
      do_write   = 1'b0;
      case (state)
         IDLE: begin
            if (clr) begin
               count_nxt = '0;
            end else if (start && (count != 4'd0)) begin
               state_nxt  = SCROLL;
               offset_nxt = '0;
               tick_nxt   = '0;
            end else if (wr_en && wr_ready) begin
               do_write  = 1'b1;
               count_nxt = count + 4'd1;
            end
         end
         SCROLL: begin
            if (stop) begin
               state_nxt  = IDLE;
               offset_nxt = '0;
               tick_nxt   = '0;
            end else if (!pause) begin
               if (tick == TICK_MAX) begin
                  tick_nxt   = '0;
                  // The gap sits at index count, so offset wraps after reaching it.
                  offset_nxt = (offset == count) ? 4'd0 : offset + 4'd1;
               end else begin
                  tick_nxt = tick + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      codes    = '0;
      blank    = '0;
      slot_idx = '0;
      for (int k = 0; k < 5; k++) begin
         slot_idx = (5'(offset) + 5'(k)) % (5'(count) + 5'd1);
         if (slot_idx == 5'(count)) blank[k] = 1'b1;
         else                       codes[3*k +: 3] = char_buf[slot_idx[2:0]];
      end
   end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl (DIV=4) against a behavioural
// model built from a character array, a run flag, a scroll position and a cycle counter.
module tb_hex_scroll_ctrl;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_code = '0;
   logic        wr_ready;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic        clr = 1'b0;
   logic [14:0] codes;
   logic [4:0]  blank;
   logic        busy;
   logic [3:0]  count;

   int checks = 0;
   int errors = 0;

   // behavioural model
   logic [2:0] m_buf [8];
   int         m_count;
   bit         m_run;
   int         m_off;
   int         m_cyc;

   hex_scroll_ctrl #(.DIV(DIV)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_code(wr_code), .wr_ready(wr_ready),
      .start(start), .stop(stop), .pause(pause), .clr(clr),
      .codes(codes), .blank(blank), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int j = 0; j < 8; j++) m_buf[j] = 3'd0;
      m_count = 0; m_run = 0; m_off = 0; m_cyc = 0;
   endfunction

   function automatic bit exp_ready();
      return !m_run && (m_count < 8) && !start && !clr;
   endfunction

   function automatic logic [14:0] exp_codes();
      logic [14:0] r = '0;
      for (int k = 0; k < 5; k++) begin
         int i = (m_off + k) % (m_count + 1);
         if (i != m_count) r[3*k +: 3] = m_buf[i];
      end
      return r;
   endfunction

   function automatic logic [4:0] exp_blank();
      logic [4:0] r = '0;
      for (int k = 0; k < 5; k++)
         if ((m_off + k) % (m_count + 1) == m_count) r[k] = 1'b1;
      return r;
   endfunction

   // Applies the inputs to the model, clocks the DUT, and drops single-cycle strobes.
   task automatic cyc(input bit we, input logic [2:0] code, input bit st, input bit sp, input bit cl);
      bit rdy;
      wr_en = we; wr_code = code; start = st; stop = sp; clr = cl;
      rdy = exp_ready();
      if (!m_run) begin
         if (cl) m_count = 0;
         else if (st && m_count > 0) begin m_run = 1; m_off = 0; m_cyc = 0; end
         else if (we && rdy) begin m_buf[m_count] = code; m_count++; end
      end else begin
         if (sp) begin m_run = 0; m_off = 0; m_cyc = 0; end
         else if (!pause) begin
            m_cyc++;
            if (m_cyc == DIV) begin m_cyc = 0; m_off = (m_off + 1) % (m_count + 1); end
         end
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (codes !== 15'd0)    begin errors++; $display("FAIL reset_codes: got %h expected %h", codes, 15'd0); end
      checks++; if (blank !== 5'b11111) begin errors++; $display("FAIL reset_blank: got %b expected %b", blank, 5'b11111); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (count !== 4'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_write_view();
      cyc(1, 3'd1, 0, 0, 0);
      cyc(1, 3'd2, 0, 0, 0);
      cyc(1, 3'd3, 0, 0, 0);
      checks++; if (count !== 4'd3) begin errors++; $display("FAIL write_count: got %0d expected 3", count); end
      checks++; if (codes !== {3'd1, 3'd0, 3'd3, 3'd2, 3'd1})
         begin errors++; $display("FAIL write_codes: got %h expected %h", codes, {3'd1, 3'd0, 3'd3, 3'd2, 3'd1}); end
      checks++; if (blank !== 5'b01000) begin errors++; $display("FAIL write_blank: got %b expected 01000", blank); end
   endtask

   task automatic test_scroll();
      cyc(0, 3'd0, 1, 0, 0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scroll_busy: got %b expected 1", busy); end
      for (int c = 1; c <= 20; c++) begin
         cyc(0, 3'd0, 0, 0, 0);
         if (c == 4) begin
            checks++; if (codes !== {3'd2, 3'd1, 3'd0, 3'd3, 3'd2} || blank !== 5'b00100)
               begin errors++; $display("FAIL scroll_offset1: got %h/%b expected %h/%b", codes, blank, {3'd2, 3'd1, 3'd0, 3'd3, 3'd2}, 5'b00100); end
         end
         checks++; if (codes !== exp_codes() || blank !== exp_blank())
            begin errors++; $display("FAIL scroll_view c=%0d: got %h/%b expected %h/%b", c, codes, blank, exp_codes(), exp_blank()); end
      end
      cyc(0, 3'd0, 0, 1, 0);
      checks++; if (busy !== 1'b0 || codes !== exp_codes() || blank !== exp_blank())
         begin errors++; $display("FAIL scroll_stop: got busy=%b %h/%b expected busy=0 %h/%b", busy, codes, blank, exp_codes(), exp_blank()); end
   endtask

   task automatic test_full();
      logic [2:0] last;
      logic [2:0] c;
      cyc(0, 3'd0, 0, 0, 1);
      for (int n = 0; n < 8; n++) begin
         c = 3'($urandom_range(0, 7));
         cyc(1, c, 0, 0, 0);
      end
      last = m_buf[7];
      checks++; if (count !== 4'd8)    begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
      cyc(1, ~last, 0, 0, 0);
      checks++; if (count !== 4'd8)    begin errors++; $display("FAIL full_ninth: got %0d expected 8", count); end
      cyc(0, 3'd0, 1, 0, 0);
      for (int n = 0; n < 40; n++) begin
         cyc(0, 3'd0, 0, 0, 0);
         checks++; if (codes !== exp_codes() || blank !== exp_blank())
            begin errors++; $display("FAIL full_view n=%0d: got %h/%b expected %h/%b", n, codes, blank, exp_codes(), exp_blank()); end
         if (m_off == 7) begin
            checks++; if (codes[2:0] !== last) begin errors++; $display("FAIL full_buf7: got %0d expected %0d", codes[2:0], last); end
         end
      end
      cyc(0, 3'd0, 0, 1, 0);
   endtask

   task automatic test_pause();
      logic [14:0] frozen;
      cyc(0, 3'd0, 1, 0, 0);
      for (int n = 0; n < 6; n++) cyc(0, 3'd0, 0, 0, 0);
      pause = 1'b1;
      frozen = codes;
      for (int n = 0; n < 10; n++) begin
         cyc(0, 3'd0, 0, 0, 0);
         checks++; if (codes !== frozen || codes !== exp_codes())
            begin errors++; $display("FAIL pause_frozen n=%0d: got %h expected %h", n, codes, frozen); end
      end
      pause = 1'b0;
      for (int n = 0; n < 8; n++) begin
         cyc(0, 3'd0, 0, 0, 0);
         checks++; if (codes !== exp_codes() || blank !== exp_blank())
            begin errors++; $display("FAIL pause_resume n=%0d: got %h/%b expected %h/%b", n, codes, blank, exp_codes(), exp_blank()); end
      end
      pause = 1'b1;
      cyc(0, 3'd0, 0, 0, 0);
      cyc(0, 3'd0, 0, 1, 0);
      pause = 1'b0;
      checks++; if (busy !== 1'b0 || codes !== exp_codes() || blank !== exp_blank())
         begin errors++; $display("FAIL pause_stop: got busy=%b %h/%b expected busy=0 %h/%b", busy, codes, blank, exp_codes(), exp_blank()); end
   endtask

   task automatic test_start_edges();
      cyc(0, 3'd0, 0, 0, 1);
      cyc(0, 3'd0, 1, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_empty: got busy=%b expected 0", busy); end
      cyc(1, 3'd5, 0, 0, 0);
      cyc(1, 3'd6, 1, 0, 0);
      checks++; if (busy !== 1'b1 || count !== 4'd1)
         begin errors++; $display("FAIL start_with_write: got busy=%b count=%0d expected busy=1 count=1", busy, count); end
      cyc(0, 3'd0, 0, 0, 1);
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL clr_in_scroll: got %0d expected 1", count); end
      cyc(0, 3'd0, 0, 1, 0);
   endtask

   task automatic test_async_reset();
      cyc(1, 3'd4, 0, 0, 0);
      cyc(0, 3'd0, 1, 0, 0);
      for (int n = 0; n < 5; n++) cyc(0, 3'd0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      checks++; if (codes !== 15'd0 || blank !== 5'b11111 || busy !== 1'b0 || count !== 4'd0 || wr_ready !== 1'b1)
         begin errors++; $display("FAIL async_reset: got %h/%b busy=%b count=%0d rdy=%b", codes, blank, busy, count, wr_ready); end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         bit we, st, sp, cl;
         logic [2:0] c;
         we = ($urandom_range(0, 2) == 0);
         st = ($urandom_range(0, 14) == 0);
         sp = ($urandom_range(0, 24) == 0);
         cl = ($urandom_range(0, 39) == 0);
         c  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) pause = ~pause;
         start = st; clr = cl;
         #0;
         checks++; if (wr_ready !== exp_ready())
            begin errors++; $display("FAIL rand_wr_ready n=%0d: got %b expected %b", n, wr_ready, exp_ready()); end
         cyc(we, c, st, sp, cl);
         checks++; if (codes !== exp_codes() || blank !== exp_blank() || busy !== m_run || count !== 4'(m_count))
            begin errors++; $display("FAIL rand_state n=%0d: got %h/%b busy=%b count=%0d expected %h/%b busy=%b count=%0d",
                                     n, codes, blank, busy, count, exp_codes(), exp_blank(), m_run, m_count); end
      end
      pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_view();
      test_scroll();
      test_full();
      test_pause();
      test_start_edges();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_scroll_ctrl.md
HEX_SCROLL_CTRL -- requirements
Module: hex_scroll_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000000, clock cycles per scroll step; legal range DIV >= 1.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_en  in  1  write strobe for one 3-bit character code.
REQ-005 SHALL have port wr_code  in  3  character code {c2,c1,c0} to append.
REQ-006 SHALL have port wr_ready  out  1  buffer accepts a write this cycle.
REQ-007 SHALL have port start  in  1  single-cycle request to begin scrolling.
REQ-008 SHALL have port stop  in  1  single-cycle request to end scrolling.
REQ-009 SHALL have port pause  in  1  level; freezes scrolling while high.
REQ-010 SHALL have port clr  in  1  single-cycle request to empty the buffer.
REQ-011 SHALL have port codes  out  15  slot k code on bits [3k+2:3k], k=0..4, one per downstream 7-segment decoder.
REQ-012 SHALL have port blank  out  5  bit k high = slot k shows the blank gap.
REQ-013 SHALL have port busy  out  1  high while in SCROLL.
REQ-014 SHALL have port count  out  4  number of stored characters, 0..8.

Function
REQ-015 SHALL hold an 8-entry x 3-bit character buffer, a write count, a step offset, a tick counter and a two-state FSM {IDLE, SCROLL}.
REQ-016 SHALL drive wr_ready = (state==IDLE) & (count<8) & ~start & ~clr, combinationally.
REQ-017 SHALL, on wr_en & wr_ready, store wr_code at buffer[count] and increment count at that edge; wr_en otherwise ignored, no state change.
REQ-018 SHALL, in IDLE on clr, set count to 0 (buffer contents don't-care); clr ignored in SCROLL.
REQ-019 SHALL, in IDLE on start with count>=1, enter SCROLL with offset=0, tick=0; start with count==0 ignored.
REQ-020 SHALL define sequence length L = count+1 (characters plus one blank gap position at index count).
REQ-021 SHALL compute, combinationally from registers, for slot k: i = (offset+k) mod L; if i==count then blank[k]=1 and slot code=3'b000, else blank[k]=0 and slot code=buffer[i].
REQ-022 SHALL, in SCROLL with pause low, increment tick each cycle; when tick==DIV-1, set tick=0 and offset=(offset+1) mod L at that edge.
REQ-023 SHALL, in SCROLL with pause high, hold tick and offset.
REQ-024 SHALL, on stop in SCROLL (paused or not), return to IDLE with offset=0, tick=0, buffer and count retained; stop in IDLE ignored.
REQ-025 SHALL, in IDLE, present the offset-0 view per REQ-021 (count==0 gives blank=5'b11111).
REQ-026 SHALL give stop priority over pause; start in SCROLL ignored.
REQ-027 SHALL keep offset < L at all times; offset never indexes past count.

Reset
REQ-028 SHALL, on reset high, immediately (asynchronously) set state=IDLE, count=0, offset=0, tick=0, all buffer entries 3'b000.
REQ-029 SHALL therefore show after reset: codes=15'd0, blank=5'b11111, busy=0, count=0, wr_ready=1 (with start, clr low).
REQ-030 SHALL, on reset asserted mid-SCROLL or mid-write, abandon the operation; no write completes on a reset-asserted edge.

Verification (DIV=4)
REQ-031 SHALL cover: reset, then write codes 1,2,3 -> count=3; slots 0..4 = 1,2,3,blank,1; blank=5'b01000.
REQ-032 SHALL cover: start with count=3 -> busy=1 next edge; every 4 cycles offset steps 0->1->2->3->0; at offset=1, slots = 2,3,blank,1,2.
REQ-033 SHALL cover: 8 writes then 9th wr_en -> wr_ready=0 after 8th, count stays 8, buffer[7] unchanged; L=9, offset wraps 8->0.
REQ-034 SHALL cover: pause high for 10 cycles mid-SCROLL -> codes, offset, tick frozen; resume completes the remaining tick count; stop while paused -> IDLE, offset 0.
REQ-035 SHALL cover: start with count=0 -> stays IDLE, busy=0; start and wr_en same cycle in IDLE with count>=1 -> write dropped, SCROLL entered.
REQ-036 SHALL cover: reset pulsed mid-SCROLL between clock edges -> outputs return to REQ-029 values before the next edge.
